code_serializer: RTL and testbench

//  Parametrised frame serialiser for the TX path. Accepts parallel key codes over a valid/ready

---
 rtl/code_serializer.sv | 145 ++++++++++++++
 tb/tb_code_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/code_serializer.sv
// Frame serialiser: a one-deep holding register feeding a preamble/data/gap bit sequencer.
// All outputs are registered; code_ready is taken straight from the holding-register flag.
module code_serializer #(
    parameter int unsigned CODE_W     = 8,
    parameter int unsigned PREAMBLE_W = 4,
    parameter logic [(PREAMBLE_W > 0 ? PREAMBLE_W : 1)-1:0] PREAMBLE = 4'b1010,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    output logic              code_ready,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done
);

    localparam int unsigned FRAME_W = PREAMBLE_W + CODE_W;
    localparam int unsigned MAX_PC  = (PREAMBLE_W > CODE_W) ? PREAMBLE_W : CODE_W;
    localparam int unsigned MAX_CNT = (MAX_PC > GAP_CYCLES) ? MAX_PC : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {StIdle, StPre, StData, StGap} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        cnt_ext;
    logic [FRAME_W-1:0] frame_q, frame_d, frame_load;
    logic [CODE_W-1:0]  pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic               tx_bit_d, tx_active_d, frame_done_d;
    logic               start;

    assign code_ready = ~pend_full_q;
    assign cnt_ext    = 32'(cnt_q);

    // Whole frame laid out so it always shifts out from the top bit.
    always_comb begin
        frame_load = '0;
        for (int i = 0; i < int'(CODE_W); i++) begin
            frame_load[i] = MSB_FIRST ? pend_q[i] : pend_q[CODE_W-1-i];
        end
        for (int i = 0; i < int'(PREAMBLE_W); i++) begin
            frame_load[CODE_W+i] = PREAMBLE[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        tx_bit_d     = IDLE_LEVEL;
        tx_active_d  = 1'b0;
        frame_done_d = 1'b0;
        start        = 1'b0;

        // The state names the bit currently on tx_bit; cnt_q is its index within that state.
        case (state_q)
            StIdle: start = pend_full_q;
            StPre: begin
                tx_bit_d    = frame_q[FRAME_W-1];
                frame_d     = frame_q << 1;
                tx_active_d = 1'b1;
                if (cnt_ext + 32'd1 == PREAMBLE_W) begin
                    state_d      = StData;
                    cnt_d        = '0;
                    frame_done_d = (CODE_W == 1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (cnt_ext + 32'd1 == CODE_W) begin
                    cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                        start   = pend_full_q;
                    end
                end else begin
                    tx_bit_d     = frame_q[FRAME_W-1];
                    frame_d      = frame_q << 1;
                    tx_active_d  = 1'b1;
                    frame_done_d = (cnt_ext + 32'd2 == CODE_W);
                    cnt_d        = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_ext + 32'd1 >= GAP_CYCLES) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    start   = pend_full_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            state_d      = (PREAMBLE_W > 0) ? StPre : StData;
            cnt_d        = '0;
            tx_bit_d     = frame_load[FRAME_W-1];
            frame_d      = frame_load << 1;
            tx_active_d  = 1'b1;
            frame_done_d = (PREAMBLE_W == 0) && (CODE_W == 1);
            pend_full_d  = 1'b0;
        end

        // Accept and start are exclusive: one needs the holding register empty, the other full.
        if (code_valid && !pend_full_q) begin
            pend_full_d = 1'b1;
            pend_d      = code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            frame_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            tx_bit      <= IDLE_LEVEL;
            tx_active   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            tx_bit      <= tx_bit_d;
            tx_active   <= tx_active_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_code_serializer.sv
// Bench for code_serializer: three configurations checked every cycle against a queue-based
// frame model, plus directed literal sequences for the documented frame shapes.
module tb_code_serializer;

    localparam int ND = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid [ND];
    logic [7:0] code  [ND];
    logic       rdy   [ND];
    logic       txb   [ND];
    logic       act   [ND];
    logic       done  [ND];

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;
    bit rand_src = 1'b0;
    int dens     = 8;

    always #5 clk = ~clk;

    code_serializer u_a (
        .clk(clk), .rst_n(rst_n), .code_valid(valid[0]), .code(code[0]),
        .code_ready(rdy[0]), .tx_bit(txb[0]), .tx_active(act[0]), .frame_done(done[0])
    );

    code_serializer #(
        .CODE_W(4), .PREAMBLE_W(0), .PREAMBLE(1'b0), .GAP_CYCLES(0), .MSB_FIRST(1'b0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .code_valid(valid[1]), .code(code[1][3:0]),
        .code_ready(rdy[1]), .tx_bit(txb[1]), .tx_active(act[1]), .frame_done(done[1])
    );

    code_serializer #(
        .IDLE_LEVEL(1'b1)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .code_valid(valid[2]), .code(code[2]),
        .code_ready(rdy[2]), .tx_bit(txb[2]), .tx_active(act[2]), .frame_done(done[2])
    );

    function automatic int pw(int d);  return (d == 1) ? 0 : 4; endfunction
    function automatic int cw(int d);  return (d == 1) ? 4 : 8; endfunction
    function automatic int gw(int d);  return (d == 1) ? 0 : 2; endfunction
    function automatic bit msb(int d); return d != 1;            endfunction
    function automatic bit idl(int d); return d == 2;            endfunction

    // Model: each entry is {tx_bit, tx_active, frame_done} for one bit time.
    logic [2:0] sched [ND][$];
    bit         pend  [ND];
    logic [7:0] pcode [ND];
    bit         acc   [ND];
    logic [3:0] expv  [ND];

    function automatic void load_frame(int d, logic [7:0] c);
        logic [3:0] pat = 4'b1010;
        for (int i = pw(d) - 1; i >= 0; i--) sched[d].push_back({pat[i], 2'b10});
        for (int k = 0; k < cw(d); k++) begin
            logic b;
            b = msb(d) ? c[cw(d)-1-k] : c[k];
            sched[d].push_back({b, 1'b1, k == cw(d) - 1});
        end
        for (int g = 0; g < gw(d); g++) sched[d].push_back({idl(d), 2'b00});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                sched[d].delete();
                pend[d] = 1'b0;
                acc[d]  = 1'b0;
                expv[d] = {1'b1, idl(d), 2'b00};
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                bit         was_pend;
                logic [2:0] e;
                was_pend = pend[d];
                acc[d]   = valid[d] && !was_pend;
                if (sched[d].size() == 0 && was_pend) begin
                    load_frame(d, pcode[d]);
                    pend[d] = 1'b0;
                end
                if (acc[d]) begin
                    pend[d]  = 1'b1;
                    pcode[d] = code[d];
                end
                if (sched[d].size() > 0) e = sched[d].pop_front();
                else e = {idl(d), 2'b00};
                expv[d] = {!pend[d], e};
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({rdy[d], txb[d], act[d], done[d]} !== expv[d]) begin
                    failures++;
                    $display("FAIL cycle_dut%0d t=%0t got{rdy,tx,act,done}=%b want=%b", d, $time,
                             {rdy[d], txb[d], act[d], done[d]}, expv[d]);
                end
            end
        end
    end

    // Random source: holds each code until the model says it was accepted.
    always @(posedge clk) begin
        #1;
        if (rand_src) begin
            for (int d = 0; d < ND; d++) begin
                if (!valid[d] || acc[d]) begin
                    if ($urandom_range(0, 9) < dens) begin
                        valid[d] = 1'b1;
                        code[d]  = 8'($urandom);
                    end else begin
                        valid[d] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk_idle_now(string name);
        for (int d = 0; d < ND; d++) begin
            chk(name, 32'({rdy[d], txb[d], act[d], done[d]}), 32'({1'b1, idl(d), 2'b00}));
        end
    endtask

    logic [31:0] r_tx, r_done, r_rdy, r_late;

    initial begin
        for (int d = 0; d < ND; d++) begin
            valid[d] = 1'b0;
            code[d]  = 8'h00;
            pend[d]  = 1'b0;
            acc[d]   = 1'b0;
            expv[d]  = {1'b1, idl(d), 2'b00};
        end
        repeat (3) @(posedge clk);
        #1 chk_idle_now("reset_state");
        #1 rst_n = 1'b1;
        check_en = 1'b1;
        repeat (3) @(posedge clk);

        // A5 on defaults: preamble, data MSB first, two gap bits.
        r_tx = '0; r_done = '0;
        @(posedge clk); #1 valid[0] = 1'b1; code[0] = 8'hA5;
        for (int e = 0; e <= 14; e++) begin
            @(posedge clk); #1;
            if (e == 0) valid[0] = 1'b0;
            @(negedge clk);
            if (e >= 1) begin
                r_tx   = {r_tx[30:0], txb[0]};
                r_done = {r_done[30:0], done[0]};
            end
        end
        chk("t1_bits", r_tx, 32'b1010_1010_0101_00);
        chk("t1_done", r_done, 32'b0000_0000_0001_00);
        repeat (10) @(posedge clk);

        // 81 then 3C queued at edge 3, then FF held while ready is low.
        r_tx = '0; r_rdy = '0; r_late = '0;
        @(posedge clk); #1 valid[0] = 1'b1; code[0] = 8'h81;
        for (int e = 0; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 0) valid[0] = 1'b0;
            if (e == 2) begin valid[0] = 1'b1; code[0] = 8'h3C; end
            if (e == 3) code[0] = 8'hFF;
            if (e == 16) valid[0] = 1'b0;
            @(negedge clk);
            if (e <= 16) r_rdy = {r_rdy[30:0], rdy[0]};
            if (e >= 13 && e <= 19) r_tx = {r_tx[30:0], txb[0]};
            if (e >= 29 && e <= 36) r_late = {r_late[30:0], txb[0]};
        end
        chk("t2_ready", r_rdy, 32'b011_0000_0000_0000_10);
        chk("t2_seam", r_tx, 32'b00_1010_0);
        chk("t3_third", r_late, 32'b1010_1111);
        repeat (10) @(posedge clk);

        // Asynchronous reset in the middle of a data field.
        @(posedge clk); #1 valid[0] = 1'b1; code[0] = 8'h5A;
        @(posedge clk); #1 valid[0] = 1'b0;
        repeat (8) @(posedge clk);
        #2 chk("t4_in_data", 32'(act[0]), 32'd1);
        rst_n = 1'b0;
        #1 chk_idle_now("t4_rst_now");
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("t4_stays_idle", 32'({txb[0], act[0], rdy[0]}), 32'b001);

        // No preamble, no gap, LSB first: frames abut.
        r_tx = '0; r_done = '0;
        @(posedge clk); #1 valid[1] = 1'b1; code[1] = 8'h01;
        for (int e = 0; e <= 9; e++) begin
            @(posedge clk); #1;
            if (e == 0) code[1] = 8'h08;
            if (e == 2) valid[1] = 1'b0;
            @(negedge clk);
            if (e >= 1 && e <= 8) begin
                r_tx   = {r_tx[30:0], txb[1]};
                r_done = {r_done[30:0], done[1]};
            end
        end
        chk("t5_bits", r_tx, 32'b1000_0001);
        chk("t5_done", r_done, 32'b0001_0001);
        repeat (5) @(posedge clk);

        // Idle-high line.
        r_tx = '0;
        @(posedge clk); #1 valid[2] = 1'b1; code[2] = 8'h00;
        for (int e = 0; e <= 14; e++) begin
            @(posedge clk); #1;
            if (e == 0) valid[2] = 1'b0;
            @(negedge clk);
            r_tx = {r_tx[30:0], txb[2]};
        end
        chk("t6_bits", r_tx, 32'b1_1010_0000_0000_11);
        repeat (5) @(posedge clk);

        // Random traffic, busy then sparse, with occasional asynchronous resets.
        rand_src = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            dens = (i < 1500) ? 8 : 2;
            if ($urandom_range(0, 599) == 0) begin
                #3 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
        end
        @(posedge clk);
        rand_src = 1'b0;
        #2;
        for (int d = 0; d < ND; d++) valid[d] = 1'b0;
        repeat (60) @(posedge clk);
        #1 chk_idle_now("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
